// File: rtl/device_special_memory_ctrl.sv
// GCI special-address register file for MIST32 devices.
// Read-only ID header, byte-masked RAM, registered response, swept clear.
module device_special_memory_ctrl #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter int          DEPTH      = 256,
    parameter logic [31:0] USEMEMSIZE = 32'h0,
    parameter logic [31:0] PRIORITY   = 32'h0,
    parameter logic [31:0] DEVICECAT  = 32'h0
) (
    input  logic                    iCLOCK,
    input  logic                    inRESET,
    input  logic                    iCLEAR,
    output logic                    oSPECIAL_BUSY,
    input  logic                    iSPECIAL_REQ,
    input  logic                    iSPECIAL_RW,
    input  logic [ADDR_WIDTH-1:0]   iSPECIAL_ADDR,
    input  logic [DATA_WIDTH/8-1:0] iSPECIAL_MASK,
    input  logic [DATA_WIDTH-1:0]   iSPECIAL_DATA,
    output logic                    oSPECIAL_VALID,
    output logic [DATA_WIDTH-1:0]   oSPECIAL_DATA,
    output logic                    oSPECIAL_ERR
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int IW = $clog2(DEPTH);

    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IW-1:0]       LAST_W  = IW'(DEPTH - 1);

    localparam logic [DATA_WIDTH-1:0] HDR0 = DATA_WIDTH'(USEMEMSIZE);
    localparam logic [DATA_WIDTH-1:0] HDR1 = DATA_WIDTH'(PRIORITY);
    localparam logic [DATA_WIDTH-1:0] HDR2 = DATA_WIDTH'(DEVICECAT);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [IW-1:0]   clrCnt;
    logic [IW-1:0]   clrCntNext;
    logic            sweepLast;
    logic            sweepWe;
    logic            accept;

    logic            addrMapped;
    logic            addrHeader;
    logic            ramHit;
    logic [IW-1:0]   idx;
    logic [DATA_WIDTH-1:0] hdrData;
    logic [DATA_WIDTH-1:0] readWord;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign sweepLast = (clrCnt == LAST_W);

    // State register and sweep counter; reset restarts the sweep at word 0
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state  <= CLEAR;
            clrCnt <= '0;
        end else begin
            state  <= stateNext;
            clrCnt <= clrCntNext;
        end
    end

    // Next state: sweep to the last word, or start a sweep on iCLEAR
    always_comb begin
        stateNext  = state;
        clrCntNext = clrCnt;
        unique case (state)
            CLEAR: begin
                if (sweepLast) begin
                    stateNext  = IDLE;
                    clrCntNext = '0;
                end else begin
                    clrCntNext = clrCnt + 1'b1;
                end
            end
            IDLE: begin
                if (iCLEAR) begin
                    stateNext  = CLEAR;
                    clrCntNext = '0;
                end
            end
        endcase
    end

    // FSM outputs: busy while sweeping, clear beats a same-cycle request
    always_comb begin
        oSPECIAL_BUSY = (state == CLEAR);
        sweepWe       = (state == CLEAR);
        accept        = (state == IDLE) && iSPECIAL_REQ && !iCLEAR;
    end

    // Address decode for header, RAM and unmapped regions
    always_comb begin
        addrMapped = ({1'b0, iSPECIAL_ADDR} < DEPTH_A);
        addrHeader = (iSPECIAL_ADDR < ADDR_WIDTH'(3));
        ramHit     = addrMapped && !addrHeader;
        idx        = iSPECIAL_ADDR[IW-1:0];
    end

    // Header word select and read data mux
    always_comb begin
        hdrData  = HDR2;
        readWord = '0;
        unique case (1'b1)
            (iSPECIAL_ADDR[1:0] == 2'd0): hdrData = HDR0;
            (iSPECIAL_ADDR[1:0] == 2'd1): hdrData = HDR1;
            default:                      hdrData = HDR2;
        endcase
        if (!addrMapped) begin
            readWord = '0;
        end else if (addrHeader) begin
            readWord = hdrData;
        end else begin
            readWord = mem[idx];
        end
    end

    // Storage: sweep zeroes one word per cycle, else byte-masked writes
    always_ff @(posedge iCLOCK) begin
        if (sweepWe) begin
            mem[clrCnt] <= '0;
        end else if (accept && iSPECIAL_RW && ramHit) begin
            for (int b = 0; b < BW; b++) begin
                if (iSPECIAL_MASK[b]) begin
                    mem[idx][b*8 +: 8] <= iSPECIAL_DATA[b*8 +: 8];
                end
            end
        end
    end

    // Registered response; read data holds until the next read completes
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            oSPECIAL_VALID <= 1'b0;
            oSPECIAL_ERR   <= 1'b0;
            oSPECIAL_DATA  <= '0;
        end else begin
            oSPECIAL_VALID <= accept;
            oSPECIAL_ERR   <= accept &&
                              (!addrMapped || (iSPECIAL_RW && addrHeader));
            if (accept && !iSPECIAL_RW) begin
                oSPECIAL_DATA <= readWord;
            end
        end
    end

endmodule

// File: tb/tb_device_special_memory_ctrl.sv
// Scoreboard bench for device_special_memory_ctrl.
// Reference model: flat word array plus header constants.
module tb_device_special_memory_ctrl;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        busy;
    logic        req;
    logic        rwS;
    logic [7:0]  addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        valid;
    logic [31:0] rdata;
    logic        err;

    always #5 clk = ~clk;

    device_special_memory_ctrl #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .DEPTH      (D),
        .USEMEMSIZE (32'h100),
        .PRIORITY   (32'h3),
        .DEVICECAT  (32'hA5)
    ) dut (
        .iCLOCK         (clk),
        .inRESET        (rst_n),
        .iCLEAR         (clear),
        .oSPECIAL_BUSY  (busy),
        .iSPECIAL_REQ   (req),
        .iSPECIAL_RW    (rwS),
        .iSPECIAL_ADDR  (addr),
        .iSPECIAL_MASK  (mask),
        .iSPECIAL_DATA  (wdata),
        .oSPECIAL_VALID (valid),
        .oSPECIAL_DATA  (rdata),
        .oSPECIAL_ERR   (err)
    );

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    int          vcyc[$];
    logic [31:0] mdl [D];
    logic [31:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] hdr(input int a);
        if (a == 0) return 32'h100;
        if (a == 1) return 32'h3;
        return 32'hA5;
    endfunction

    task automatic mdlClear();
        for (int i = 0; i < D; i++) mdl[i] = 32'h0;
    endtask

    // Monitor: pop expected response whenever the DUT presents VALID
    exp_t x;
    always @(negedge clk) begin
        if (rst_n) begin
            if (err && !valid) begin
                errors++;
                $display("FAIL err_without_valid at cycle %0d", cyc);
            end
            if (valid) begin
                vcyc.push_back(cyc);
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid data=%h err=%b", rdata, err);
                end else begin
                    x = sb.pop_front();
                    checks++;
                    if (rdata !== x.d || err !== x.e) begin
                        errors++;
                        $display("FAIL response got data=%h err=%b exp data=%h err=%b",
                                 rdata, err, x.d, x.e);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Drive one request cycle; model the expected response when accepted
    task automatic issue(input bit rw, input int a, input logic [3:0] m,
                         input logic [31:0] d, input bit clr);
        exp_t e;
        bit   mapped;
        bit   hw;
        req   = 1'b1;
        rwS   = rw;
        addr  = a[7:0];
        mask  = m;
        wdata = d;
        clear = clr;
        mapped = (a < D);
        hw     = (a < 3);
        if (clr) begin
            mdlClear();
        end else begin
            if (!rw) begin
                e.d  = !mapped ? 32'h0 : (hw ? hdr(a) : mdl[a]);
                e.e  = !mapped;
                held = e.d;
            end else begin
                e.d = held;
                e.e = !mapped || hw;
                if (mapped && !hw) begin
                    for (int b = 0; b < 4; b++)
                        if (m[b]) mdl[a][b*8 +: 8] = d[b*8 +: 8];
                end
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req   = 1'b0;
        clear = 1'b0;
    endtask

    // Count busy cycles (bounded); optionally poke a request while busy
    task automatic waitBusy(input int expn, input string nm, input int reqAt);
        int n = 0;
        forever begin
            @(negedge clk);
            if (!busy || n > 100) begin
                req = 1'b0;
                break;
            end
            n++;
            req  = (n == reqAt);
            rwS  = 1'b0;
            addr = 8'd9;
        end
        check(nm, n, expn);
    endtask

    task automatic checkReset(input string nm);
        check({nm, "_busy"},  {31'b0, busy},  32'h1);
        check({nm, "_valid"}, {31'b0, valid}, 32'h0);
        check({nm, "_data"},  rdata,          32'h0);
        check({nm, "_err"},   {31'b0, err},   32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        clear = 1'b0;
        req   = 1'b0;
        rwS   = 1'b0;
        addr  = '0;
        mask  = '0;
        wdata = '0;
        held  = 32'h0;
        mdlClear();
        #2;
        checkReset("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitBusy(D, "reset_sweep_len", -1);

        issue(0, 0, 4'h0, 0, 0);
        issue(0, 1, 4'h0, 0, 0);
        issue(0, 2, 4'h0, 0, 0);
        issue(0, 5, 4'h0, 0, 0);

        issue(1, 4, 4'hF, 32'h11223344, 0);
        issue(1, 4, 4'h5, 32'hAABBCCDD, 0);
        issue(0, 4, 4'h0, 0, 0);
        check("masked_model", mdl[4], 32'h11BB33DD);

        issue(1, 1, 4'hF, 32'hFFFFFFFF, 0);
        issue(0, 1, 4'h0, 0, 0);
        issue(0, 20, 4'h0, 0, 0);
        issue(1, 6, 4'h0, 32'hFFFFFFFF, 0);
        issue(0, 6, 4'h0, 0, 0);

        issue(1, 7, 4'hF, 32'hDEAD, 0);
        issue(0, 7, 4'h0, 0, 0);
        issue(1, 8, 4'hF, 32'h1234, 0);
        repeat (3) @(posedge clk);
        #1;
        n = vcyc.size();
        check("b2b_count", (n >= 3), 32'h1);
        if (n >= 3) begin
            check("b2b_contig1", vcyc[n-2] - vcyc[n-3], 32'h1);
            check("b2b_contig2", vcyc[n-1] - vcyc[n-2], 32'h1);
        end

        issue(1, 9, 4'hF, 32'h55, 0);
        issue(1, 10, 4'hF, 32'h77, 1);
        waitBusy(D, "clear_sweep_len", 5);
        issue(0, 9, 4'h0, 0, 0);
        issue(0, 10, 4'h0, 0, 0);
        issue(0, 0, 4'h0, 0, 0);
        issue(0, 1, 4'h0, 0, 0);
        issue(0, 2, 4'h0, 0, 0);

        issue(1, 11, 4'hF, 32'hCAFE, 0);
        issue(0, 0, 4'h0, 0, 0);
        issue(0, 3, 4'h0, 0, 1);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkReset("midsweep_reset");
        held = 32'h0;
        mdlClear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitBusy(D, "reset2_sweep_len", -1);
        issue(0, 11, 4'h0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                issue($urandom_range(0, 1), $urandom_range(0, 19),
                      4'($urandom), $urandom, 0);
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
